prbs31_checker: RTL
===================

Name: prbs31_checker

Overview:
- Serial PRBS31 receiver/checker for polynomial x^31 + x^28 + 1.
- Sits at the sink end of the serial PRBS31 test link and consumes the generator's 1-bit stream: b[n] = b[n-31] ^ b[n-28].
- Self-synchronizing: it seeds from received bits, acquires lock, counts bit errors, and drops lock on excessive errors.
- Results (lock, error pulse, counters) drive the status outputs of the top-level test harness.

Parameters:
- LOCK_CNT, 64: consecutive matching bits required in VERIFY to declare lock.
- UNLOCK_ERR, 8: errors within one window that force loss of lock.
- UNLOCK_WIN, 256: window length in valid bits for unlock evaluation.
- CNT_W, 16: width of err_count and bit_count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (despite the name).
- din  input  1  received serial bit.
- din_valid  input  1  din qualifier; state advances only when 1.
- clear_cnt  input  1  synchronous clear of err_count and bit_count.
- locked  output  1  1 while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per errored bit while locked.
- err_count  output  CNT_W  saturating error count while locked.
- bit_count  output  CNT_W  saturating count of valid bits checked while locked.

Behaviour:
- Reset (rst_n=1, async):
  - 31-bit shift register sr = 0; state = SEED.
  - All internal counters = 0.
  - locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
- Shift register:
  - On every valid bit: sr <= {sr[29:0], din}; sr[0] holds the newest bit.
  - Receiver always loads the received bit, never the predicted bit (self-sync).
  - One flipped input bit therefore yields exactly 3 mismatches: at arrival, +28 bits, +31 bits.
- Prediction and error flags (evaluated before the shift):
  - pred = sr[30] ^ sr[27]; mis = pred ^ din.
  - zero = next sr value is all zeros.
- SEED:
  - Count valid bits, no checking.
  - After the 31st valid bit: move to VERIFY, clear good_cnt.
- VERIFY:
  - Per valid bit: if mis or zero, good_cnt <= 0; else good_cnt++.
  - When good_cnt reaches LOCK_CNT: move to LOCKED; locked=1 from the next cycle.
  - The all-zero stream can never lock.
- LOCKED, per valid bit:
  - bad = mis | zero.
  - err_pulse=1 on the following cycle iff bad.
  - err_count += bad, saturating at 2^CNT_W-1.
  - bit_count += 1, saturating at 2^CNT_W-1.
  - win_cnt++ and win_err += bad.
- Window and unlock:
  - When win_err reaches UNLOCK_ERR: go to SEED (locked=0 next cycle); clear win_cnt and win_err.
  - Counters err_count and bit_count are preserved across unlock.
  - When win_cnt reaches UNLOCK_WIN without an unlock: clear win_cnt and win_err.
  - Unlock takes priority over the window wrap on the same bit.
- din_valid=0: no state, sr, or counter change; err_pulse=0.
- clear_cnt:
  - Zeroes err_count and bit_count; does not affect state, sr, or window counters.
  - If clear_cnt coincides with a counting bit, clear wins (result 0).
- Latency:
  - err_pulse and counters update on the clock edge that samples the bit; visible 1 cycle after the bit's valid cycle.
  - locked asserts 1 cycle after the LOCK_CNT-th good bit.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Clean stream, continuous valid: reference generator (seed 1, output = MSB, so 30 zeros then 1) → locked rises 1 cycle after valid bit 95 (31 seed + 64 good); after 10000 bits err_count=0, bit_count=9905.
- Single flip while locked: invert bit 500 → err_pulse at bits 500, 528, 531; err_count=3; locked stays 1.
- Burst: invert bits 1000-1015 → window errors reach 8 → locked=0; clean data resumes → relock after 95 further valid bits; err_count ≥8 and retained across unlock.
- All-zero input for 2000 valid bits → locked never asserts; err_count=0.
- Valid gaps: din_valid=1 one cycle in three, clean stream → lock after exactly 95 valid bits; no change during invalid cycles.
- Control: clear_cnt pulse while locked → err_count=bit_count=0, locked unchanged; rst_n=1 for one cycle mid-lock → all outputs 0 immediately, relock after 95 valid bits.

Source files
------------

// File: rtl/prbs31_if.sv
// Serial PRBS31 checker link: received bit stream in, lock and error status out.
// master = stream source/status sink, slave = checker.
interface prbs31_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clear_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output din, din_valid, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  din, din_valid, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_checker.sv
// Self-synchronizing PRBS31 (x^31+x^28+1) checker: seed, verify, lock, count errors.
// Ports: clk, rst_n (async, active-high), bus (slave): din/din_valid/clear_cnt in, status out.
module prbs31_checker #(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_ERR = 8,
  parameter int UNLOCK_WIN = 256,
  parameter int CNT_W      = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  prbs31_if.slave   bus
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(UNLOCK_WIN + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  localparam logic [4:0]    SEED_LAST = 5'd30;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(UNLOCK_WIN - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(UNLOCK_ERR - 1);

  state_t           state;
  state_t           state_nxt;
  logic [30:0]      sr;
  logic [4:0]       seed_cnt;
  logic [GW-1:0]    good_cnt;
  logic [WW-1:0]    win_cnt;
  logic [EW-1:0]    win_err;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             locked_o;

  logic [30:0] sr_nxt;
  logic        mis;
  logic        zero;
  logic        bad;
  logic        v;
  logic        seed_done;
  logic        good_done;
  logic        unlock;
  logic        wrap;
  logic        lk_bit;

  // Prediction uses the register before the received bit is shifted in.
  assign v         = bus.din_valid;
  assign sr_nxt    = {sr[29:0], bus.din};
  assign mis       = sr[30] ^ sr[27] ^ bus.din;
  assign zero      = (sr_nxt == 31'd0);
  assign bad       = mis | zero;
  assign seed_done = (seed_cnt == SEED_LAST);
  assign good_done = !bad && (good_cnt == GOOD_LAST);
  assign unlock    = bad && (win_err == ERR_LAST);
  assign wrap      = (win_cnt == WIN_LAST);
  assign lk_bit    = v && (state == LOCKED);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= SEED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SEED:    if (v && seed_done) state_nxt = VERIFY;
      VERIFY:  if (v && good_done) state_nxt = LOCKED;
      LOCKED:  if (v && unlock)    state_nxt = SEED;
      default: state_nxt = SEED;
    endcase
  end

  always_comb begin
    locked_o = (state == LOCKED);
  end

  // Self-sync: always load the received bit, never the predicted one.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sr       <= '0;
      seed_cnt <= '0;
      good_cnt <= '0;
    end else if (v) begin
      sr <= sr_nxt;
      if (state == SEED) begin
        seed_cnt <= seed_done ? 5'd0 : seed_cnt + 5'd1;
        if (seed_done) good_cnt <= '0;
      end
      if (state == VERIFY) begin
        good_cnt <= bad ? '0 : good_cnt + GW'(1);
      end
    end
  end

  // Unlock beats the window wrap; both restart the window.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (lk_bit) begin
      if (unlock || wrap) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        win_err <= win_err + EW'(bad);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      err_pulse_q <= lk_bit && bad;
      if (bus.clear_cnt) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end else if (lk_bit) begin
        if (bad && err_cnt_q != '1)
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        if (bit_cnt_q != '1)
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.locked    = locked_o;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_cnt_q;
  assign bus.bit_count = bit_cnt_q;

endmodule
